// File: rtl/data_sram_bridge.sv
// M-stage bridge to a handshaked data SRAM bus: one request per load/store, 3 stall cycles minimum.
// Latency: req the cycle after access, +1 per bus wait cycle; stallM holds the pipeline until data_ok.
module data_sram_bridge #(
    parameter logic [31:0] PHYS_MASK = 32'h1FFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memrdM,
    input  logic [3:0]  memwenM,
    input  logic [1:0]  memsizeM,
    input  logic [31:0] addrM,
    input  logic [31:0] wdataM,
    output logic [31:0] rdataM,
    output logic        stallM,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]  state;
    logic        access;
    logic [31:0] wdataRep;

    assign access = memrdM | (|memwenM);

    always_comb begin
        wdataRep = wdataM;
        case (memsizeM)
            2'd0:    wdataRep = {4{wdataM[7:0]}};
            2'd1:    wdataRep = {2{wdataM[15:0]}};
            default: wdataRep = wdataM;
        endcase
    end

    // Bus fields are plain registers so they keep their last value outside ADDR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            wr     <= 1'b0;
            size   <= 2'd0;
            wstrb  <= 4'd0;
            addr   <= 32'd0;
            wdata  <= 32'd0;
            rdataM <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        addr  <= addrM & PHYS_MASK;
                        wstrb <= memwenM;
                        size  <= memsizeM;
                        wr    <= |memwenM;
                        wdata <= wdataRep;
                        state <= ADDR;
                    end
                end
                ADDR: begin
                    if (addr_ok) state <= DATA;
                end
                DATA: begin
                    if (data_ok) begin
                        if (!wr) rdataM <= rdata;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req    = (state == ADDR);
    assign stallM = ~rst & (((state == IDLE) & access) | (state == ADDR) | (state == DATA));

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge with a small bus responder of configurable wait cycles.
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        memrdM;
    logic [3:0]  memwenM;
    logic [1:0]  memsizeM;
    logic [31:0] addrM;
    logic [31:0] wdataM;
    logic [31:0] rdataM;
    logic        stallM;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    int tests = 0;
    int fails = 0;
    int cycle = 0;

    int          stalls, reqCnt, reqCyc, done;
    logic [31:0] capAddr, capWdata;
    logic [3:0]  capWstrb;
    logic [1:0]  capSize;
    logic        capWr;
    int          firstReq;

    data_sram_bridge dut (
        .clk(clk), .rst(rst), .memrdM(memrdM), .memwenM(memwenM), .memsizeM(memsizeM),
        .addrM(addrM), .wdataM(wdataM), .rdataM(rdataM), .stallM(stallM), .req(req),
        .wr(wr), .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts a cycle after a posedge with the access already driven; returns at the DONE negedge.
    task automatic runAccess(input int aWait, input int dWait, input logic [31:0] rv);
        int aCnt = 0;
        int dCnt = 0;
        int inData = 0;
        stalls = 0; reqCnt = 0; reqCyc = -1; done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            addr_ok = 1'b0;
            data_ok = 1'b0;
            if (!stallM) begin
                done = 1;
                break;
            end
            stalls++;
            if (req) begin
                reqCnt++;
                if (reqCyc < 0) reqCyc = cycle;
                capAddr = addr; capWdata = wdata; capWstrb = wstrb; capSize = size; capWr = wr;
                if (aCnt == aWait) addr_ok = 1'b1; else aCnt++;
            end else if (inData != 0) begin
                if (dCnt == dWait) begin
                    data_ok = 1'b1;
                    rdata   = rv;
                end else dCnt++;
            end
            @(posedge clk);
            if (addr_ok) inData = 1;
            #1;
        end
        addr_ok = 1'b0;
        data_ok = 1'b0;
        chk("completed", done, 1);
    endtask

    task automatic idleInputs();
        memrdM = 1'b0; memwenM = 4'd0; memsizeM = 2'd2; addrM = 32'd0; wdataM = 32'd0;
    endtask

    initial begin
        rst = 1'b1; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'd0;
        idleInputs();
        #1;
        chk("rst_stall", {31'd0, stallM}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_wr", {31'd0, wr}, 32'd0);
        chk("rst_size", {30'd0, size}, 32'd0);
        chk("rst_wstrb", {28'd0, wstrb}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_rdataM", rdataM, 32'd0);
        chk("rst_stall_idle", {31'd0, stallM}, 32'd0);

        // Load word, both handshakes one cycle late.
        @(posedge clk); #1;
        memrdM = 1'b1; memsizeM = 2'd2; addrM = 32'h8000_0010;
        runAccess(1, 1, 32'hDEAD_BEEF);
        chk("lw_addr", capAddr, 32'h0000_0010);
        chk("lw_wr", {31'd0, capWr}, 32'd0);
        chk("lw_stalls", stalls, 5);
        chk("lw_reqcnt", reqCnt, 2);
        chk("lw_rdataM", rdataM, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        idleInputs();
        @(negedge clk);
        chk("lw_after_stall", {31'd0, stallM}, 32'd0);
        chk("lw_after_req", {31'd0, req}, 32'd0);
        chk("lw_addr_held", addr, 32'h0000_0010);

        // sb, immediate handshakes.
        @(posedge clk); #1;
        memwenM = 4'b0010; memsizeM = 2'd0; addrM = 32'h0000_0102; wdataM = 32'h1234_56A5;
        runAccess(0, 0, 32'h1111_1111);
        chk("sb_wdata", capWdata, 32'hA5A5_A5A5);
        chk("sb_wstrb", {28'd0, capWstrb}, 32'h2);
        chk("sb_wr", {31'd0, capWr}, 32'd1);
        chk("sb_addr", capAddr, 32'h0000_0102);
        chk("sb_stalls", stalls, 3);
        chk("sb_rdataM", rdataM, 32'hDEAD_BEEF);
        @(posedge clk); #1;

        // sh directly after sb.
        memwenM = 4'b1100; memsizeM = 2'd1; addrM = 32'h0000_0200; wdataM = 32'h0000_BEEF;
        runAccess(0, 0, 32'h2222_2222);
        chk("sh_wdata", capWdata, 32'hBEEF_BEEF);
        chk("sh_size", {30'd0, capSize}, 32'd1);
        chk("sh_wstrb", {28'd0, capWstrb}, 32'hC);
        chk("sh_rdataM", rdataM, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;

        // Two consecutive loads: req cycles 4 apart, one each.
        memrdM = 1'b1; memsizeM = 2'd2; addrM = 32'h0000_0040;
        runAccess(0, 0, 32'h0000_0A0A);
        firstReq = reqCyc;
        chk("ld1_reqcnt", reqCnt, 1);
        chk("ld1_rdataM", rdataM, 32'h0000_0A0A);
        @(posedge clk); #1;
        addrM = 32'h0000_0044;
        runAccess(0, 0, 32'h0000_0B0B);
        chk("ld2_reqcnt", reqCnt, 1);
        chk("ld2_gap", reqCyc - firstReq, 4);
        chk("ld2_rdataM", rdataM, 32'h0000_0B0B);
        chk("ld2_addr", capAddr, 32'h0000_0044);
        @(posedge clk); #1;
        idleInputs();

        // Reset while in DATA, then a stale data_ok.
        memrdM = 1'b1; addrM = 32'h0000_0080;
        @(posedge clk); #1;
        addr_ok = 1'b1;
        @(posedge clk); #1;
        addr_ok = 1'b0;
        @(negedge clk);
        chk("pre_rst_stall", {31'd0, stallM}, 32'd1);
        chk("pre_rst_req", {31'd0, req}, 32'd0);
        idleInputs();
        rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, req}, 32'd0);
        chk("mid_rst_stall", {31'd0, stallM}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        data_ok = 1'b1; rdata = 32'h5555_5555;
        @(posedge clk); #1;
        data_ok = 1'b0;
        @(negedge clk);
        chk("post_rst_rdataM", rdataM, 32'd0);
        chk("post_rst_req", {31'd0, req}, 32'd0);
        chk("post_rst_stall", {31'd0, stallM}, 32'd0);

        // Spurious data_ok in IDLE.
        @(posedge clk); #1;
        data_ok = 1'b1; rdata = 32'h6666_6666;
        @(posedge clk); #1;
        data_ok = 1'b0;
        @(negedge clk);
        chk("spur_idle_stall", {31'd0, stallM}, 32'd0);
        chk("spur_idle_req", {31'd0, req}, 32'd0);
        chk("spur_idle_rdataM", rdataM, 32'd0);

        // addr_ok during DATA must not disturb the transaction.
        @(posedge clk); #1;
        memrdM = 1'b1; addrM = 32'h0000_00C0;
        @(posedge clk); #1;
        addr_ok = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("spur_data_stall", {31'd0, stallM}, 32'd1);
        chk("spur_data_req", {31'd0, req}, 32'd0);
        @(posedge clk); #1;
        addr_ok = 1'b0;
        @(negedge clk);
        chk("spur_data_hold", {31'd0, stallM}, 32'd1);
        data_ok = 1'b1; rdata = 32'h7777_7777;
        @(posedge clk); #1;
        data_ok = 1'b0;
        @(negedge clk);
        chk("spur_done_stall", {31'd0, stallM}, 32'd0);
        chk("spur_done_rdataM", rdataM, 32'h7777_7777);
        @(posedge clk); #1;
        idleInputs();
        @(negedge clk);
        chk("final_req", {31'd0, req}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
